dec_to_bcd_key_encoder: RTL and testbench
=========================================

Name: dec_to_bcd_key_encoder

Overview:
- Inverse of the 8421 BCD-to-decimal decoder. Takes ten decimal key lines and produces a debounced 8421 BCD code.
- Synchronizes the lines, priority-encodes them (highest index wins) and debounces the press and the release.
- Presents each accepted key once on a valid/ready output register.
- Sits between a panel or keypad front end and any BCD consumer, including the decimal decoder itself.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to accept a press or a release. Legal range is 2 to 255.
- CNT_W, 8, width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- I  in  10  decimal key lines, active-high, asynchronous to CLK. I[n] means decimal n.
- READY  in  1  consumer accepts the code when READY and VALID are both high at a clock edge.
- CLR_OVR  in  1  synchronous clear of OVERRUN.
- A  out  1  BCD bit 0, weight 1.
- B  out  1  BCD bit 1, weight 2.
- C  out  1  BCD bit 2, weight 4.
- D  out  1  BCD bit 3, weight 8.
- VALID  out  1  {D,C,B,A} holds an unconsumed key code.
- OVERRUN  out  1  sticky flag: a key was accepted while the previous code was still pending.
- BUSY  out  1  FSM is not in IDLE.

Behaviour:
- Reset (RST high at an edge):
  - A, B, C, D, VALID, OVERRUN, BUSY all go to 0.
  - Both synchronizer stages go to 0; FSM goes to IDLE; counter goes to 0.
  - Reset wins over every other event in the same cycle.
  - A key held through reset is debounced and emitted again after RST falls.
- Synchronizer: two flop stages on all 10 lines; s is the second stage. I becomes visible in s after 2 edges.
- Encoder, combinational on s:
  - any = OR of s.
  - enc = index of the highest set bit of s. Example: s = 10'b00_0010_1000 gives enc = 5.
  - I[0] alone encodes 0, which is a valid key.
  - enc is only meaningful when any is 1.
- FSM:
  - IDLE: if any, then cand <= enc, cnt <= 1, go to DEB.
  - DEB:
    - If any is 0 or enc != cand, go to IDLE with no output.
    - Else if cnt == DEBOUNCE_CYCLES-1, capture and go to HELD with cnt <= 0.
    - Else cnt <= cnt+1.
  - HELD (waits for release):
    - If any, cnt <= 0.
    - Else if cnt == DEBOUNCE_CYCLES-1, go to IDLE.
    - Else cnt <= cnt+1.
    - A change of the pressed key while in HELD is ignored; no second code is emitted.
- Capture (the edge on which DEB exits to HELD):
  - If VALID is 0, or VALID and READY are both 1 at that edge: {D,C,B,A} <= cand and VALID stays or goes to 1.
  - Otherwise the output register is unchanged and OVERRUN <= 1; the new code is dropped.
- Handshake:
  - When VALID and READY are high at an edge with no capture, VALID <= 0 and A–D hold their last value.
  - A–D never change while VALID is 1 and READY is 0.
  - READY high while VALID is 0 has no effect.
- OVERRUN:
  - Cleared by CLR_OVR.
  - If a set and CLR_OVR occur in the same edge, the set wins.
- BUSY = (state != IDLE), registered with the state.
- Latency: I stable from edge 0 gives VALID high after edge DEBOUNCE_CYCLES+2. That is edge 6 for the default of 4.
- Glitch rules:
  - A press pulse shorter than DEBOUNCE_CYCLES synchronized samples produces nothing.
  - A release gap shorter than DEBOUNCE_CYCLES samples does not re-arm, so there is no double key.

Test Plan:
- Default parameters. I = 10'h020 from edge 0 with READY = 0 → VALID = 1 and {D,C,B,A} = 4'b0101 after edge 6. Values hold while READY = 0. READY = 1 for one edge → VALID = 0 on the next edge.
- I = 10'h208 (keys 9 and 3 together) → code 4'b1001. I = 10'h001 → code 4'b0000 with VALID = 1.
- I = 10'h004 for 3 cycles, then 0 → VALID stays 0 and the FSM returns to IDLE. Then 10'h004 held → 4'b0010 after edge 6 from the new press.
- Key 7 is held, released for 2 cycles, then held again → exactly one 4'b0111 transfer. A release of ≥4 samples followed by a new press of key 7 → a second transfer.
- READY = 0. Press key 1 and fully release it, then press key 2 → A–D stay 4'b0001 and OVERRUN = 1. CLR_OVR pulse → OVERRUN = 0.
- Press key 8 and assert RST for 1 cycle while in DEB → all outputs 0. With key 8 still held, 4'b1000 becomes valid 6 edges after RST deasserts.

Source files
------------

// File: rtl/dec_to_bcd_key_encoder.sv
// Decimal key-line to 8421 BCD encoder: two-flop sync, priority encode,
// press/release debounce and a valid/ready output register with overrun flag.
module dec_to_bcd_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] I,
  input  logic       READY,
  input  logic       CLR_OVR,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       VALID,
  output logic       OVERRUN,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [9:0]       s1;
  logic [9:0]       s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cand;
  logic [3:0]       code;
  logic             any;
  logic [3:0]       enc;
  logic             capture;
  logic             take;

  assign any = |s;

  // Ascending scan so the highest set line is the last one written.
  always_comb begin
    enc = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (s[i]) enc = 4'(i);
    end
  end

  assign capture = (state == DEB) && any && (enc == cand) && (cnt == LAST);
  assign take    = !VALID || READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1      <= '0;
      s       <= '0;
      state   <= IDLE;
      cnt     <= '0;
      cand    <= '0;
      code    <= '0;
      VALID   <= 1'b0;
      OVERRUN <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      s1 <= I;
      s  <= s1;

      unique case (state)
        IDLE: begin
          if (any) begin
            cand  <= enc;
            cnt   <= ONE;
            state <= DEB;
            BUSY  <= 1'b1;
          end
        end
        DEB: begin
          if (!any || enc != cand) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else if (cnt == LAST) begin
            cnt   <= '0;
            state <= HELD;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HELD: begin
          if (any) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase

      if (capture && take) begin
        code  <= cand;
        VALID <= 1'b1;
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end

      // A dropped code must stay visible even if software clears now.
      if (capture && !take) begin
        OVERRUN <= 1'b1;
      end else if (CLR_OVR) begin
        OVERRUN <= 1'b0;
      end
    end
  end

  assign A = code[0];
  assign B = code[1];
  assign C = code[2];
  assign D = code[3];

endmodule

// File: tb/tb_dec_to_bcd_key_encoder.sv
// Directed bench for dec_to_bcd_key_encoder with a sample-run model
// checked every cycle, plus literal expectations at key points.
module tb_dec_to_bcd_key_encoder;

  localparam int DB = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] I = '0;
  logic       READY = 1'b0;
  logic       CLR_OVR = 1'b0;
  logic       A, B, C, D;
  logic       VALID, OVERRUN, BUSY;

  int errors = 0;
  int checks = 0;
  int xfers = 0;
  int base;
  logic chk_en = 1'b0;

  dec_to_bcd_key_encoder #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .I(I), .READY(READY), .CLR_OVR(CLR_OVR),
    .A(A), .B(B), .C(C), .D(D),
    .VALID(VALID), .OVERRUN(OVERRUN), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the line vector is seen two samples late; a key is accepted
  // after DB equal samples, and re-armed after DB empty samples.
  logic [9:0] m_s1, m_s2;
  int         m_run, m_rel;
  logic [3:0] m_cand, m_code;
  logic       m_held, m_valid, m_ovr, m_busy;

  always @(posedge CLK) begin : model
    logic       a, emit, held;
    logic [3:0] e, cand;
    int         run, rel;
    a = |m_s2;
    e = 4'd0;
    for (int k = 0; k < 10; k++) if (m_s2[k]) e = 4'(k);
    if (RST) begin
      m_s1 <= '0; m_s2 <= '0; m_run <= 0; m_rel <= 0;
      m_cand <= '0; m_code <= '0; m_held <= 1'b0;
      m_valid <= 1'b0; m_ovr <= 1'b0; m_busy <= 1'b0;
    end else begin
      m_s1 <= I;
      m_s2 <= m_s1;
      emit = 1'b0;
      run = m_run; rel = m_rel; cand = m_cand; held = m_held;
      if (!held) begin
        if (run == 0) begin
          if (a) begin run = 1; cand = e; end
        end else if (a && e == cand) begin
          if (run + 1 == DB) begin
            emit = 1'b1; held = 1'b1; rel = 0; run = 0;
          end else run = run + 1;
        end else run = 0;
      end else begin
        if (a) rel = 0;
        else if (rel + 1 == DB) begin held = 1'b0; rel = 0; end
        else rel = rel + 1;
      end
      m_run <= run; m_rel <= rel; m_cand <= cand; m_held <= held;
      m_busy <= held || (run > 0);
      if (emit && (!m_valid || READY)) begin
        m_code <= cand; m_valid <= 1'b1;
      end else if (m_valid && READY) m_valid <= 1'b0;
      if (emit && m_valid && !READY) m_ovr <= 1'b1;
      else if (CLR_OVR) m_ovr <= 1'b0;
    end
  end

  always @(posedge CLK)
    if (!RST && VALID === 1'b1 && READY) xfers <= xfers + 1;

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cyc_valid", int'(VALID), int'(m_valid));
      chk("cyc_code", int'({D, C, B, A}), int'(m_code));
      chk("cyc_overrun", int'(OVERRUN), int'(m_ovr));
      chk("cyc_busy", int'(BUSY), int'(m_busy));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_ready();
    READY = 1'b1; step(1); READY = 1'b0;
  endtask

  initial begin
    step(1);
    chk_en = 1'b1;
    step(1);
    RST = 1'b0;
    chk("rst_valid", int'(VALID), 0);
    chk("rst_code", int'({D, C, B, A}), 0);
    chk("rst_ovr_busy", int'({OVERRUN, BUSY}), 0);

    I = 10'h020; step(5);
    chk("k5_not_yet", int'(VALID), 0);
    step(1);
    chk("k5_valid", int'(VALID), 1);
    chk("k5_code", int'({D, C, B, A}), 5);
    step(3);
    chk("k5_hold", int'({VALID, D, C, B, A}), 5'h15);
    I = '0; pulse_ready();
    chk("k5_consumed", int'(VALID), 0);
    step(10);

    I = 10'h208; step(6);
    chk("k93_code", int'({VALID, D, C, B, A}), 5'h19);
    pulse_ready(); I = '0; step(10);
    I = 10'h001; step(6);
    chk("k0_code", int'({VALID, D, C, B, A}), 5'h10);
    pulse_ready(); I = '0; step(10);

    I = 10'h004; step(3); I = '0; step(8);
    chk("glitch_valid", int'(VALID), 0);
    chk("glitch_idle", int'(BUSY), 0);
    I = 10'h004; step(6);
    chk("k2_code", int'({VALID, D, C, B, A}), 5'h12);
    pulse_ready(); I = '0; step(10);

    READY = 1'b1; base = xfers;
    I = 10'h080; step(10);
    I = '0; step(2);
    I = 10'h080; step(10);
    chk("k7_one_xfer", xfers - base, 1);
    I = '0; step(6);
    I = 10'h080; step(10);
    chk("k7_two_xfer", xfers - base, 2);
    READY = 1'b0; I = '0; step(10);

    I = 10'h002; step(8); I = '0; step(8);
    I = 10'h004; step(8);
    chk("ovr_code", int'({VALID, D, C, B, A}), 5'h11);
    chk("ovr_set", int'(OVERRUN), 1);
    CLR_OVR = 1'b1; step(1); CLR_OVR = 1'b0;
    chk("ovr_clr", int'(OVERRUN), 0);
    pulse_ready(); I = '0; step(10);

    I = 10'h100; step(4);
    chk("deb_busy", int'(BUSY), 1);
    RST = 1'b1; step(1); RST = 1'b0;
    chk("mid_rst", int'({VALID, D, C, B, A, OVERRUN, BUSY}), 0);
    step(5);
    chk("k8_not_yet", int'(VALID), 0);
    step(1);
    chk("k8_code", int'({VALID, D, C, B, A}), 5'h18);
    pulse_ready(); I = '0; step(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
